bsg_tx_ctrl: RTL and testbench

Transmit sequencer for the binary-signal-generator datapath. It accepts host bytes over a valid/ready handshake into the two data registers BSG_DATA_0/BSG_DATA_1, used as a ping-pong pair. It drives `data_flag`, which selects the register routed to the Gray encoder and modulator, and advances it on each modulator byte-done pulse. It also owns the STATUS and INTFLAG control bits and the interrupt request, all in the SYS_CLK domain.

---
 rtl/bsg_tx_ctrl.sv | 114 +++++++++++
 tb/tb_bsg_tx_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_tx_ctrl.sv
// Transmit sequencer: ping-pong byte buffer between the host write port and
// the Gray encoder/modulator, plus STATUS, INTFLAG and the interrupt request.
module bsg_tx_ctrl #(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic             SYS_CLK,
    input  logic             SYS_RST,
    input  logic [DW-1:0]    wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             tx_enable,
    input  logic             int_mask,
    input  logic             int_clr,
    input  logic             byte_done,
    output logic [DW-1:0]    data_0,
    output logic [DW-1:0]    data_1,
    output logic             data_flag,
    output logic             tx_active,
    output logic             int_flag,
    output logic             bsg_int,
    output logic [CNT_W-1:0] tx_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       full_reg, full_next;
    logic             wr_ptr_reg;
    logic             data_flag_reg, data_flag_next;
    logic             int_flag_reg, int_flag_next;
    logic [CNT_W-1:0] tx_count_reg, tx_count_next;
    logic [DW-1:0]    slot_reg [2];
    logic             wr_accept;

    assign wr_ready  = ~full_reg[wr_ptr_reg];
    assign wr_accept = wr_valid & wr_ready;

    always_comb begin
        state_next     = state_reg;
        full_next      = full_reg;
        data_flag_next = data_flag_reg;
        int_flag_next  = int_flag_reg;
        tx_count_next  = tx_count_reg;

        if (wr_accept)
            full_next[wr_ptr_reg] = 1'b1;
        if (int_clr)
            int_flag_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (tx_enable & full_reg[data_flag_reg])
                    state_next = RUN;
            end
            RUN: begin
                if (byte_done) begin
                    // A same-cycle write can only land in the other slot, so
                    // it counts toward keeping the stream going.
                    full_next[data_flag_reg] = 1'b0;
                    data_flag_next = ~data_flag_reg;
                    tx_count_next  = tx_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (!(tx_enable & full_next[~data_flag_reg]))
                        state_next = IDLE;
                    if (full_next == 2'b00)
                        int_flag_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_reg     <= IDLE;
            full_reg      <= 2'b00;
            wr_ptr_reg    <= 1'b0;
            data_flag_reg <= 1'b0;
            int_flag_reg  <= 1'b0;
            tx_count_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            full_reg      <= full_next;
            data_flag_reg <= data_flag_next;
            int_flag_reg  <= int_flag_next;
            tx_count_reg  <= tx_count_next;
            if (wr_accept)
                wr_ptr_reg <= ~wr_ptr_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge SYS_CLK) begin
                if (SYS_RST)
                    slot_reg[gi] <= '0;
                else if (wr_accept && (wr_ptr_reg == 1'(gi)))
                    slot_reg[gi] <= wr_data;
            end
        end
    endgenerate

    assign data_0    = slot_reg[0];
    assign data_1    = slot_reg[1];
    assign data_flag = data_flag_reg;
    assign tx_active = (state_reg == RUN);
    assign int_flag  = int_flag_reg;
    assign bsg_int   = int_flag_reg & int_mask;
    assign tx_count  = tx_count_reg;

endmodule

// File: tb/tb_bsg_tx_ctrl.sv
// Bench for bsg_tx_ctrl: directed vector table, randomized run against a
// queue-based reference model, and a counter wrap sequence.
module tb_bsg_tx_ctrl;

    localparam int DW    = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic             tx_enable;
    logic             int_mask;
    logic             int_clr;
    logic             byte_done;
    logic [DW-1:0]    data_0;
    logic [DW-1:0]    data_1;
    logic             data_flag;
    logic             tx_active;
    logic             int_flag;
    logic             bsg_int;
    logic [CNT_W-1:0] tx_count;

    always #5 clk = ~clk;

    bsg_tx_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
        .SYS_CLK  (clk),
        .SYS_RST  (rst),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .tx_enable(tx_enable),
        .int_mask (int_mask),
        .int_clr  (int_clr),
        .byte_done(byte_done),
        .data_0   (data_0),
        .data_1   (data_1),
        .data_flag(data_flag),
        .tx_active(tx_active),
        .int_flag (int_flag),
        .bsg_int  (bsg_int),
        .tx_count (tx_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pending bytes in acceptance order, slot index derived
    // from how many bytes have been accepted / sent so far.
    logic [7:0] m_q[$];
    logic [7:0] m_mem [2];
    int         m_acc;
    int         m_sent;
    bit         m_active;
    bit         m_int;
    logic [7:0] m_cnt;

    task automatic model_edge(input bit r, input bit v, input logic [7:0] d,
                              input bit en, input bit clr, input bit bd);
        bit acc_ok;
        bit done;
        if (r) begin
            m_q.delete();
            m_mem[0] = 8'h00;
            m_mem[1] = 8'h00;
            m_acc    = 0;
            m_sent   = 0;
            m_active = 0;
            m_int    = 0;
            m_cnt    = 8'h00;
        end else begin
            acc_ok = v && (m_q.size() < 2);
            done   = m_active && bd;
            if (clr) m_int = 0;
            if (m_active) begin
                if (acc_ok) begin
                    m_q.push_back(d);
                    m_mem[m_acc % 2] = d;
                    m_acc++;
                end
                if (done) begin
                    void'(m_q.pop_front());
                    m_sent++;
                    m_cnt = m_cnt + 8'd1;
                    m_active = en && (m_q.size() > 0);
                    if (m_q.size() == 0) m_int = 1;
                end
            end else begin
                m_active = en && (m_q.size() > 0);
                if (acc_ok) begin
                    m_q.push_back(d);
                    m_mem[m_acc % 2] = d;
                    m_acc++;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs for one cycle, advance the model, sample 1 ns after the edge.
    task automatic step(input bit r, input bit v, input logic [7:0] d,
                        input bit en, input bit m, input bit clr, input bit bd);
        rst = r; wr_valid = v; wr_data = d; tx_enable = en;
        int_mask = m; int_clr = clr; byte_done = bd;
        @(posedge clk);
        model_edge(r, v, d, en, clr, bd);
        #1;
    endtask

    task automatic check_model(input int cyc);
        chk("m_wr_ready",  int'(wr_ready),  int'(m_q.size() < 2));
        chk("m_data_flag", int'(data_flag), m_sent % 2);
        chk("m_tx_active", int'(tx_active), int'(m_active));
        chk("m_int_flag",  int'(int_flag),  int'(m_int));
        chk("m_bsg_int",   int'(bsg_int),   int'(m_int & int_mask));
        chk("m_tx_count",  int'(tx_count),  int'(m_cnt));
        chk("m_data_0",    int'(data_0),    int'(m_mem[0]));
        chk("m_data_1",    int'(data_1),    int'(m_mem[1]));
        $display("[TB] cyc %0d rdy=%0b df=%0b act=%0b if=%0b cnt=%0d", cyc,
                 wr_ready, data_flag, tx_active, int_flag, tx_count);
    endtask

    typedef struct {
        bit         r, v;
        logic [7:0] d;
        bit         en, m, clr, bd;
        bit         rdy, df, act, intf, bi;
        logic [7:0] cnt, d0, d1;
    } vec_t;

    vec_t vecs [32];

    initial begin
        //          r  v  d      en m  clr bd  rdy df act if bi  cnt    d0     d1
        vecs[0]  = '{1, 0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00};
        vecs[1]  = '{0, 1, 8'hA5, 1, 1, 0, 0,  1, 0, 0, 0, 0, 8'd0, 8'hA5, 8'h00};
        vecs[2]  = '{0, 0, 8'h00, 1, 1, 0, 0,  1, 0, 1, 0, 0, 8'd0, 8'hA5, 8'h00};
        vecs[3]  = '{0, 0, 8'h00, 1, 1, 0, 1,  1, 1, 0, 1, 1, 8'd1, 8'hA5, 8'h00};
        vecs[4]  = '{0, 0, 8'h00, 0, 1, 1, 0,  1, 1, 0, 0, 0, 8'd1, 8'hA5, 8'h00};
        vecs[5]  = '{1, 0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00};
        vecs[6]  = '{0, 1, 8'h11, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'd0, 8'h11, 8'h00};
        vecs[7]  = '{0, 1, 8'h22, 0, 0, 0, 0,  0, 0, 0, 0, 0, 8'd0, 8'h11, 8'h22};
        vecs[8]  = '{0, 1, 8'h33, 0, 0, 0, 0,  0, 0, 0, 0, 0, 8'd0, 8'h11, 8'h22};
        vecs[9]  = '{0, 1, 8'h33, 1, 0, 0, 0,  0, 0, 1, 0, 0, 8'd0, 8'h11, 8'h22};
        vecs[10] = '{0, 1, 8'h33, 1, 0, 0, 1,  1, 1, 1, 0, 0, 8'd1, 8'h11, 8'h22};
        vecs[11] = '{0, 1, 8'h33, 1, 0, 0, 0,  0, 1, 1, 0, 0, 8'd1, 8'h33, 8'h22};
        vecs[12] = '{0, 0, 8'h00, 1, 0, 0, 1,  1, 0, 1, 0, 0, 8'd2, 8'h33, 8'h22};
        vecs[13] = '{0, 0, 8'h00, 0, 0, 0, 0,  1, 0, 1, 0, 0, 8'd2, 8'h33, 8'h22};
        vecs[14] = '{0, 0, 8'h00, 0, 0, 0, 1,  1, 1, 0, 1, 0, 8'd3, 8'h33, 8'h22};
        vecs[15] = '{0, 0, 8'h00, 0, 0, 1, 0,  1, 1, 0, 0, 0, 8'd3, 8'h33, 8'h22};
        vecs[16] = '{0, 1, 8'h44, 1, 0, 0, 0,  1, 1, 0, 0, 0, 8'd3, 8'h33, 8'h44};
        vecs[17] = '{0, 0, 8'h00, 1, 0, 0, 0,  1, 1, 1, 0, 0, 8'd3, 8'h33, 8'h44};
        vecs[18] = '{0, 0, 8'h00, 1, 1, 1, 1,  1, 0, 0, 1, 1, 8'd4, 8'h33, 8'h44};
        vecs[19] = '{0, 0, 8'h00, 0, 1, 1, 0,  1, 0, 0, 0, 0, 8'd4, 8'h33, 8'h44};
        vecs[20] = '{0, 1, 8'h55, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8'd4, 8'h55, 8'h44};
        vecs[21] = '{0, 1, 8'h66, 0, 0, 0, 0,  0, 0, 0, 0, 0, 8'd4, 8'h55, 8'h66};
        vecs[22] = '{0, 0, 8'h00, 1, 0, 0, 0,  0, 0, 1, 0, 0, 8'd4, 8'h55, 8'h66};
        vecs[23] = '{0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 0, 8'd4, 8'h55, 8'h66};
        vecs[24] = '{0, 0, 8'h00, 0, 0, 0, 1,  1, 1, 0, 0, 0, 8'd5, 8'h55, 8'h66};
        vecs[25] = '{0, 0, 8'h00, 1, 0, 0, 0,  1, 1, 1, 0, 0, 8'd5, 8'h55, 8'h66};
        vecs[26] = '{0, 1, 8'h77, 1, 0, 0, 1,  1, 0, 1, 0, 0, 8'd6, 8'h77, 8'h66};
        vecs[27] = '{0, 0, 8'h00, 1, 0, 0, 1,  1, 1, 0, 1, 0, 8'd7, 8'h77, 8'h66};
        vecs[28] = '{0, 1, 8'h88, 0, 0, 1, 0,  1, 1, 0, 0, 0, 8'd7, 8'h77, 8'h88};
        vecs[29] = '{0, 1, 8'h99, 0, 0, 0, 0,  0, 1, 0, 0, 0, 8'd7, 8'h99, 8'h88};
        vecs[30] = '{0, 0, 8'h00, 1, 0, 0, 0,  0, 1, 1, 0, 0, 8'd7, 8'h99, 8'h88};
        vecs[31] = '{1, 0, 8'h00, 1, 0, 0, 1,  1, 0, 0, 0, 0, 8'd0, 8'h00, 8'h00};

        rst = 1; wr_valid = 0; wr_data = 0; tx_enable = 0;
        int_mask = 0; int_clr = 0; byte_done = 0;
        step(1, 0, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 32; i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].en, vecs[i].m,
                 vecs[i].clr, vecs[i].bd);
            chk($sformatf("v%0d_wr_ready", i),  int'(wr_ready),  int'(vecs[i].rdy));
            chk($sformatf("v%0d_data_flag", i), int'(data_flag), int'(vecs[i].df));
            chk($sformatf("v%0d_tx_active", i), int'(tx_active), int'(vecs[i].act));
            chk($sformatf("v%0d_int_flag", i),  int'(int_flag),  int'(vecs[i].intf));
            chk($sformatf("v%0d_bsg_int", i),   int'(bsg_int),   int'(vecs[i].bi));
            chk($sformatf("v%0d_tx_count", i),  int'(tx_count),  int'(vecs[i].cnt));
            chk($sformatf("v%0d_data_0", i),    int'(data_0),    int'(vecs[i].d0));
            chk($sformatf("v%0d_data_1", i),    int'(data_1),    int'(vecs[i].d1));
            $display("[TB] vec %0d rdy=%0b df=%0b act=%0b if=%0b cnt=%0d d0=%02h d1=%02h",
                     i, wr_ready, data_flag, tx_active, int_flag, tx_count, data_0, data_1);
        end

        // Randomized traffic against the reference model.
        step(1, 0, 8'h00, 0, 0, 0, 0);
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 1) == 1,
                 8'($urandom),
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 3);
            check_model(c);
        end

        // Counter wrap: 2^CNT_W single-byte transfers.
        step(1, 0, 8'h00, 0, 0, 0, 0);
        for (int b = 0; b < (1 << CNT_W); b++) begin
            step(0, 1, 8'(b), 1, 0, 0, 0);
            step(0, 0, 8'h00, 1, 0, 0, 0);
            step(0, 0, 8'h00, 1, 0, 1, 1);
            if (b == (1 << CNT_W) - 2)
                chk("wrap_cnt_max", int'(tx_count), (1 << CNT_W) - 1);
        end
        check_model(-1);
        chk("wrap_cnt_zero", int'(tx_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
